// File: rtl/score4_game_ctrl.sv
// score4_game_ctrl: Connect-4 game controller (cursor, gravity drop, turns, win highlight).
// Optional one-level undo is enabled by defining SCORE4_UNDO_EN.
module score4_game_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   left,
    input  logic                   right,
    input  logic                   put,
    input  logic                   undo,
    input  logic                   new_game,
    input  logic                   chk_done,
    input  logic                   chk_win,
    input  logic [1:0]             chk_dir,
    input  logic [RW-1:0]          chk_row,
    input  logic [CW-1:0]          chk_col,
    output logic [ROWS*COLS*2-1:0] panel,
    output logic [COLS-1:0]        play,
    output logic                   player,
    output logic [RW-1:0]          last_row,
    output logic [CW-1:0]          last_col,
    output logic                   chk_req,
    output logic                   invalid_move,
    output logic                   full_panel,
    output logic                   game_over,
    output logic [1:0]             winner
);
    localparam int CELLS = ROWS * COLS;
    localparam int HW    = $clog2(ROWS + 1);
    localparam int NW    = $clog2(CELLS + 1);
    localparam int KW    = $clog2(WIN_LEN + 1);

    typedef enum logic [2:0] {MOVE, DROP, CHECK, HILITE, OVER} state_t;

    state_t        state;
    logic [CW-1:0] cur;
    logic [HW-1:0] height [COLS];
    logic [NW-1:0] count;
    logic [KW-1:0] hl_k;
    logic [1:0]    hl_dir;
    logic [RW-1:0] hl_row;
    logic [CW-1:0] hl_col;
    int            drop_r;
    int            hl_r;
    int            hl_c;
    int            dr;
    int            dc;
`ifdef SCORE4_UNDO_EN
    logic          undo_ok;
`else
    logic          unused_undo;
    assign unused_undo = undo;
`endif

    // Signed cell coordinates so off-board highlight cells simply never match a real cell.
    always_comb begin
        dr = 1;
        dc = 0;
        case (hl_dir)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        hl_r   = int'(hl_row) + int'(hl_k) * dr;
        hl_c   = int'(hl_col) + int'(hl_k) * dc;
        drop_r = ROWS - 1 - int'(height[cur]);
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state        <= MOVE;
            panel        <= '0;
            play         <= COLS'(1);
            cur          <= '0;
            player       <= 1'b0;
            for (int c = 0; c < COLS; c++) height[c] <= '0;
            count        <= '0;
            last_row     <= '0;
            last_col     <= '0;
            chk_req      <= 1'b0;
            invalid_move <= 1'b0;
            full_panel   <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'd0;
            hl_k         <= '0;
            hl_dir       <= 2'd0;
            hl_row       <= '0;
            hl_col       <= '0;
`ifdef SCORE4_UNDO_EN
            undo_ok      <= 1'b0;
`endif
        end else begin
            invalid_move <= 1'b0;
            case (state)
                MOVE: begin
                    if (put) begin
                        if (height[cur] == HW'(ROWS)) invalid_move <= 1'b1;
                        else state <= DROP;
                    end
`ifdef SCORE4_UNDO_EN
                    else if (undo) begin
                        if (undo_ok) begin
                            for (int r = 0; r < ROWS; r++)
                                for (int c = 0; c < COLS; c++)
                                    if (r == int'(last_row) && c == int'(last_col))
                                        panel[(r*COLS+c)*2 +: 2] <= 2'd0;
                            height[last_col] <= height[last_col] - HW'(1);
                            count            <= count - NW'(1);
                            player           <= ~player;
                            cur              <= last_col;
                            play             <= COLS'(1) << last_col;
                            undo_ok          <= 1'b0;
                        end else begin
                            invalid_move <= 1'b1;
                        end
                    end
`endif
                    else if (left != right) begin
                        if (left) begin
                            if (cur == '0) invalid_move <= 1'b1;
                            else begin
                                cur  <= cur - CW'(1);
                                play <= play >> 1;
                            end
                        end else begin
                            if (cur == CW'(COLS - 1)) invalid_move <= 1'b1;
                            else begin
                                cur  <= cur + CW'(1);
                                play <= play << 1;
                            end
                        end
                    end
                end
                DROP: begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            if (r == drop_r && c == int'(cur))
                                panel[(r*COLS+c)*2 +: 2] <= {player, ~player};
                    height[cur] <= height[cur] + HW'(1);
                    count       <= count + NW'(1);
                    last_row    <= RW'(drop_r);
                    last_col    <= cur;
                    chk_req     <= 1'b1;
                    state       <= CHECK;
                end
                CHECK: begin
                    if (chk_done) begin
                        chk_req <= 1'b0;
                        if (chk_win) begin
                            winner <= {player, ~player};
                            hl_k   <= '0;
                            hl_dir <= chk_dir;
                            hl_row <= chk_row;
                            hl_col <= chk_col;
                            state  <= HILITE;
                        end else if (count == NW'(CELLS)) begin
                            full_panel <= 1'b1;
                            game_over  <= 1'b1;
                            state      <= OVER;
                        end else begin
                            player <= ~player;
                            state  <= MOVE;
`ifdef SCORE4_UNDO_EN
                            undo_ok <= 1'b1;
`endif
                        end
                    end
                end
                HILITE: begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            if (r == hl_r && c == hl_c)
                                panel[(r*COLS+c)*2 +: 2] <= 2'd3;
                    if (hl_k == KW'(WIN_LEN - 1)) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        hl_k <= hl_k + KW'(1);
                    end
                end
                OVER: ;
                default: state <= MOVE;
            endcase
        end
    end

endmodule

// File: tb/tb_score4_game_ctrl.sv
// tb_score4_game_ctrl: directed and randomized checks of score4_game_ctrl against a board model.
// Undo-specific expectations follow SCORE4_UNDO_EN.
module tb_score4_game_ctrl;
    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;
    localparam int RW      = 3;
    localparam int CW      = 3;
    localparam int CELLS   = ROWS * COLS;
    localparam int PW      = CELLS * 2;

    logic          clk = 1'b0;
    logic          rst, left, right, put, undo, new_game, chk_done, chk_win;
    logic [1:0]    chk_dir;
    logic [RW-1:0] chk_row;
    logic [CW-1:0] chk_col;
    logic [PW-1:0] panel;
    logic [COLS-1:0] play;
    logic          player, chk_req, invalid_move, full_panel, game_over;
    logic [RW-1:0] last_row;
    logic [CW-1:0] last_col;
    logic [1:0]    winner;

    int errors = 0;
    int checks = 0;

    int board [ROWS][COLS];
    int mcur, mplayer, mcount, mwinner, mlast_r, mlast_c;
    bit mover, mfull, mundo_ok;

    score4_game_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .put(put), .undo(undo),
        .new_game(new_game), .chk_done(chk_done), .chk_win(chk_win), .chk_dir(chk_dir),
        .chk_row(chk_row), .chk_col(chk_col), .panel(panel), .play(play), .player(player),
        .last_row(last_row), .last_col(last_col), .chk_req(chk_req),
        .invalid_move(invalid_move), .full_panel(full_panel), .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] modelPanel();
        logic [PW-1:0] p;
        p = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                p[(r*COLS+c)*2 +: 2] = 2'(board[r][c]);
        return p;
    endfunction

    function automatic int colHeight(input int c);
        int n;
        n = 0;
        for (int r = 0; r < ROWS; r++) if (board[r][c] != 0) n++;
        return n;
    endfunction

    task automatic resetModel();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = 0;
        mcur = 0; mplayer = 0; mcount = 0; mwinner = 0;
        mover = 0; mfull = 0; mundo_ok = 0; mlast_r = 0; mlast_c = 0;
    endtask

    task automatic checkState(input string tag, input bit exp_inv);
        logic [127:0] e_play;
        e_play = 128'(1) << mcur;
        checkOutput({tag, ":panel"}, 128'(panel), 128'(modelPanel()));
        checkOutput({tag, ":play"}, 128'(play), e_play);
        checkOutput({tag, ":player"}, 128'(player), 128'(mplayer));
        checkOutput({tag, ":invalid"}, 128'(invalid_move), 128'(exp_inv));
        checkOutput({tag, ":game_over"}, 128'(game_over), 128'(mover));
        checkOutput({tag, ":full"}, 128'(full_panel), 128'(mfull));
        checkOutput({tag, ":winner"}, 128'(winner), 128'(mwinner));
        checkOutput({tag, ":chk_req"}, 128'(chk_req), 128'(0));
    endtask

    task automatic applyStimulus(input bit l, input bit r, input bit p, input bit u, input bit ng);
        left = l; right = r; put = p; undo = u; new_game = ng;
        @(posedge clk);
        #1;
        left = 0; right = 0; put = 0; undo = 0; new_game = 0;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic newGame();
        applyStimulus(0, 0, 0, 0, 1);
        resetModel();
        checkState("new_game", 0);
        checkOutput("new_game:last_row", 128'(last_row), 128'(0));
        checkOutput("new_game:last_col", 128'(last_col), 128'(0));
    endtask

    task automatic moveCursor(input int dir);
        bit inv;
        inv = !mover && (mcur + dir < 0 || mcur + dir >= COLS);
        applyStimulus(dir < 0, dir > 0, 0, 0, 0);
        if (!mover && !inv) mcur += dir;
        checkState("move", inv);
    endtask

    task automatic goTo(input int col);
        for (int i = 0; i < COLS && mcur != col && !mover; i++)
            moveCursor(col > mcur ? 1 : -1);
    endtask

    task automatic undoMove();
        bit inv;
        inv = 0;
        applyStimulus(0, 0, 0, 1, 0);
`ifdef SCORE4_UNDO_EN
        if (!mover) begin
            if (mundo_ok) begin
                board[mlast_r][mlast_c] = 0;
                mcount--;
                mplayer ^= 1;
                mcur = mlast_c;
                mundo_ok = 0;
            end else begin
                inv = 1;
            end
        end
`endif
        checkState("undo", inv);
    endtask

    // One complete put transaction, with the bench acting as the external win checker.
    task automatic dropPiece(input bit win, input int dly, input logic [1:0] dir,
                             input int hr, input int hc);
        int h, r, c, dr, dc;
        h = colHeight(mcur);
        applyStimulus(0, 0, 1, 0, 0);
        if (mover) begin
            checkState("put_over", 0);
            return;
        end
        if (h == ROWS) begin
            checkState("put_full", 1);
            return;
        end
        checkOutput("drop:chk_req", 128'(chk_req), 128'(0));
        idleCycle();
        board[ROWS-1-h][mcur] = mplayer + 1;
        mcount++;
        mlast_r = ROWS - 1 - h;
        mlast_c = mcur;
        checkOutput("drop:panel", 128'(panel), 128'(modelPanel()));
        checkOutput("drop:last_row", 128'(last_row), 128'(mlast_r));
        checkOutput("drop:last_col", 128'(last_col), 128'(mlast_c));
        checkOutput("check:chk_req", 128'(chk_req), 128'(1));
        for (int i = 0; i < dly; i++) begin
            idleCycle();
            checkOutput("check_wait:chk_req", 128'(chk_req), 128'(1));
        end
        chk_done = 1; chk_win = win; chk_dir = dir;
        chk_row = RW'(hr); chk_col = CW'(hc);
        idleCycle();
        chk_done = 0; chk_win = 0;
        if (win) begin
            mwinner = mplayer + 1;
            checkOutput("win:chk_req", 128'(chk_req), 128'(0));
            checkOutput("win:winner", 128'(winner), 128'(mwinner));
            checkOutput("win:game_over", 128'(game_over), 128'(0));
            case (dir)
                2'd0:    begin dr = 0; dc = 1;  end
                2'd1:    begin dr = 1; dc = 0;  end
                2'd2:    begin dr = 1; dc = 1;  end
                default: begin dr = 1; dc = -1; end
            endcase
            for (int k = 0; k < WIN_LEN; k++) begin
                idleCycle();
                r = hr + k * dr;
                c = hc + k * dc;
                if (r >= 0 && r < ROWS && c >= 0 && c < COLS) board[r][c] = 3;
                checkOutput("hilite:panel", 128'(panel), 128'(modelPanel()));
                checkOutput("hilite:game_over", 128'(game_over), 128'(k == WIN_LEN - 1));
            end
            mover = 1;
            checkState("win_over", 0);
        end else if (mcount == CELLS) begin
            mfull = 1;
            mover = 1;
            checkState("board_full", 0);
        end else begin
            mplayer ^= 1;
            mundo_ok = 1;
            checkState("turn", 0);
        end
    endtask

    initial begin
        rst = 1; left = 0; right = 0; put = 0; undo = 0; new_game = 0;
        chk_done = 0; chk_win = 0; chk_dir = 0; chk_row = 0; chk_col = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        resetModel();
        checkState("reset", 0);
        checkOutput("reset:last_row", 128'(last_row), 128'(0));
        checkOutput("reset:last_col", 128'(last_col), 128'(0));

        $display("[TB] cursor edges");
        moveCursor(-1);
        checkOutput("left_edge:play", 128'(play), 128'(7'b0000001));
        idleCycle();
        checkState("inv_pulse_end", 0);
        for (int i = 0; i < 6; i++) moveCursor(1);
        moveCursor(1);
        checkOutput("right_edge:play", 128'(play), 128'(7'b1000000));
        checkOutput("right_edge:invalid", 128'(invalid_move), 128'(1));
        applyStimulus(1, 1, 0, 0, 0);
        checkState("left_right_both", 0);

        $display("[TB] two drops in column 3");
        newGame();
        goTo(3);
        dropPiece(0, 1, 2'd0, 0, 0);
        dropPiece(0, 0, 2'd0, 0, 0);
        checkOutput("c3:cell53", 128'(panel[(5*COLS+3)*2 +: 2]), 128'(1));
        checkOutput("c3:cell43", 128'(panel[(4*COLS+3)*2 +: 2]), 128'(2));
        checkOutput("c3:player", 128'(player), 128'(0));
        checkOutput("c3:last_row", 128'(last_row), 128'(4));

        $display("[TB] full column");
        newGame();
        for (int i = 0; i < ROWS; i++) dropPiece(0, i % 3, 2'd0, 0, 0);
        dropPiece(0, 0, 2'd0, 0, 0);
        moveCursor(1);

        $display("[TB] anti-diagonal win");
        newGame();
        goTo(1);
        dropPiece(1, 2, 2'd3, 2, 3);
        checkOutput("anti:cell23", 128'(panel[(2*COLS+3)*2 +: 2]), 128'(3));
        checkOutput("anti:cell32", 128'(panel[(3*COLS+2)*2 +: 2]), 128'(3));
        checkOutput("anti:cell41", 128'(panel[(4*COLS+1)*2 +: 2]), 128'(3));
        checkOutput("anti:cell50", 128'(panel[(5*COLS+0)*2 +: 2]), 128'(3));
        checkOutput("anti:winner", 128'(winner), 128'(1));
        moveCursor(1);
        dropPiece(0, 0, 2'd0, 0, 0);
        undoMove();

        $display("[TB] clipped highlight");
        newGame();
        dropPiece(1, 0, 2'd0, 0, 5);

        $display("[TB] full board");
        newGame();
        for (int c = 0; c < COLS; c++) begin
            goTo(c);
            for (int i = 0; i < ROWS; i++) dropPiece(0, $urandom_range(0, 2), 2'd0, 0, 0);
        end
        checkOutput("full:full_panel", 128'(full_panel), 128'(1));
        checkOutput("full:game_over", 128'(game_over), 128'(1));
        dropPiece(0, 0, 2'd0, 0, 0);
        newGame();

        $display("[TB] new_game during CHECK");
        goTo(4);
        applyStimulus(0, 0, 1, 0, 0);
        idleCycle();
        checkOutput("midchk:chk_req", 128'(chk_req), 128'(1));
        chk_done = 1; chk_win = 1;
        applyStimulus(0, 0, 0, 0, 1);
        chk_done = 0; chk_win = 0;
        resetModel();
        checkState("midchk_reset", 0);
        idleCycle();
        checkState("midchk_after", 0);

        $display("[TB] undo");
        newGame();
        goTo(2);
        dropPiece(0, 1, 2'd0, 0, 0);
        undoMove();
`ifdef SCORE4_UNDO_EN
        checkOutput("undo:cell52", 128'(panel[(5*COLS+2)*2 +: 2]), 128'(0));
        checkOutput("undo:player", 128'(player), 128'(0));
        undoMove();
        checkOutput("undo2:invalid", 128'(invalid_move), 128'(1));
`else
        undoMove();
`endif

        $display("[TB] random play");
        newGame();
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (mover) newGame();
            else if (op < 3) moveCursor(-1);
            else if (op < 6) moveCursor(1);
            else if (op < 9)
                dropPiece($urandom_range(0, 24) == 0, $urandom_range(0, 3),
                          2'($urandom_range(0, 3)), $urandom_range(0, ROWS - 1),
                          $urandom_range(0, COLS - 1));
            else undoMove();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
